// File: rtl/riscv_dm_pkg.sv
// Shared DMI definitions used by the debug transports, the DMI arbiter and riscv_dm.
package riscv_dm_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;

  // Request op encodings
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP   = 2'b00;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ  = 2'b01;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE = 2'b10;

  // Response status encodings
  localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_SUCCESS = 2'b00;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_FAILED  = 2'b10;
  localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_BUSY    = 2'b11;

  typedef struct packed {
    logic [DMI_ADDR_WIDTH-1:0] addr;
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10,
    DELIVER   = 2'b11
  } dmi_arb_state_e;

endpackage

// File: rtl/dmi_arbiter_rr.sv
// Combinational round-robin picker: first requesting channel after last_grant, wrapping.
module dmi_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [OWN_W-1:0]   grant_idx,
  output logic               grant_any
);

  int               idx_s;
  logic [OWN_W-1:0] idx_w_s;

  // Walk the channels starting just after the previous winner and take the first one requesting
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {OWN_W{1'b0}};
    grant_any = 1'b0;
    idx_s     = 0;
    idx_w_s   = {OWN_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s   = (int'(last_grant) + i) % NUM_REQ;
      idx_w_s = OWN_W'(idx_s);
      if (!grant_any && req[idx_w_s]) begin
        grant[idx_w_s] = 1'b1;
        grant_idx      = idx_w_s;
        grant_any      = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// N-to-1 DMI arbiter: round-robin grant, one transaction outstanding, response routed
// back to the issuing channel, and a response timeout with late-response draining.
module dmi_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = riscv_dm_pkg::DMI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = riscv_dm_pkg::DMI_DATA_WIDTH,
  parameter int OP_WIDTH       = riscv_dm_pkg::DMI_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]                 resp_valid_o,
  input  logic [NUM_REQ-1:0]                 resp_ready_i,
  output logic [DATA_WIDTH-1:0]              resp_data_o,
  output logic [OP_WIDTH-1:0]                resp_op_o,
  output logic                               dm_req_valid_o,
  input  logic                               dm_req_ready_i,
  output logic [ADDR_WIDTH-1:0]              dm_req_addr_o,
  output logic [DATA_WIDTH-1:0]              dm_req_data_o,
  output logic [OP_WIDTH-1:0]                dm_req_op_o,
  input  logic                               dm_resp_valid_i,
  output logic                               dm_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]              dm_resp_data_i,
  input  logic [OP_WIDTH-1:0]                dm_resp_op_i,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner_o,
  output logic                               busy_o,
  output logic                               timeout_o
);

  import riscv_dm_pkg::*;

  localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_BITS-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_BITS'(TIMEOUT_CYCLES - 1)
                                                                : {TO_BITS{1'b0}};

  dmi_arb_state_e        state_r;
  logic                  stale_r;
  logic [OWN_W-1:0]      last_grant_r;
  logic [OWN_W-1:0]      owner_r;
  logic [TO_BITS-1:0]    counter_r;
  logic [ADDR_WIDTH-1:0] dm_addr_r;
  logic [DATA_WIDTH-1:0] dm_data_r;
  logic [OP_WIDTH-1:0]   dm_op_r;
  logic [DATA_WIDTH-1:0] resp_data_r;
  logic [OP_WIDTH-1:0]   resp_op_r;
  logic                  timeout_r;

  logic [NUM_REQ-1:0]    grant_s;
  logic [OWN_W-1:0]      grant_idx_s;
  logic                  grant_any_s;
  logic                  grant_en_s;

  dmi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s),
    .grant_any  (grant_any_s)
  );

  // A grant is only possible from IDLE once any late DM response has been drained
  assign grant_en_s = (state_r == IDLE) && !stale_r && grant_any_s;

  // Transaction FSM: grant, issue downstream, wait (with timeout), deliver upstream
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      stale_r      <= 1'b0;
      last_grant_r <= OWN_W'(NUM_REQ - 1);
      owner_r      <= {OWN_W{1'b0}};
      counter_r    <= {TO_BITS{1'b0}};
      dm_addr_r    <= {ADDR_WIDTH{1'b0}};
      dm_data_r    <= {DATA_WIDTH{1'b0}};
      dm_op_r      <= {OP_WIDTH{1'b0}};
      resp_data_r  <= {DATA_WIDTH{1'b0}};
      resp_op_r    <= {OP_WIDTH{1'b0}};
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      // A response arriving after its timeout belongs to nobody: swallow it
      if (stale_r && dm_resp_valid_i && (state_r != WAIT_RESP)) begin
        stale_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (grant_en_s) begin
            dm_addr_r    <= req_addr_i[grant_idx_s];
            dm_data_r    <= req_data_i[grant_idx_s];
            dm_op_r      <= req_op_i[grant_idx_s];
            owner_r      <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          if (dm_req_ready_i) begin
            counter_r <= {TO_BITS{1'b0}};
            state_r   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dm_resp_valid_i) begin
            resp_data_r <= dm_resp_data_i;
            resp_op_r   <= dm_resp_op_i;
            counter_r   <= {TO_BITS{1'b0}};
            state_r     <= DELIVER;
          end else if (TO_EN && (counter_r == TO_LAST)) begin
            resp_data_r <= {DATA_WIDTH{1'b0}};
            resp_op_r   <= OP_WIDTH'(DMI_RESP_FAILED);
            timeout_r   <= 1'b1;
            stale_r     <= 1'b1;
            counter_r   <= {TO_BITS{1'b0}};
            state_r     <= DELIVER;
          end else begin
            counter_r <= counter_r + TO_BITS'(1'b1);
          end
        end
        DELIVER: begin
          if (resp_ready_i[owner_r]) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Accept strobe goes only to the channel winning arbitration this cycle
  always_comb begin
    req_ready_o = {NUM_REQ{1'b0}};
    if (grant_en_s) begin
      req_ready_o = grant_s;
    end else begin
      req_ready_o = {NUM_REQ{1'b0}};
    end
  end

  // Response valid is steered to the owning channel only
  always_comb begin
    resp_valid_o = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_o[i] = (state_r == DELIVER) && (owner_r == OWN_W'(i));
    end
  end

  assign dm_req_valid_o  = (state_r == ISSUE);
  assign dm_req_addr_o   = dm_addr_r;
  assign dm_req_data_o   = dm_data_r;
  assign dm_req_op_o     = dm_op_r;
  assign dm_resp_ready_o = (state_r == WAIT_RESP) || stale_r;
  assign resp_data_o     = resp_data_r;
  assign resp_op_o       = resp_op_r;
  assign owner_o         = owner_r;
  assign busy_o          = (state_r != IDLE) || stale_r;
  assign timeout_o       = timeout_r;

endmodule
